i2c_master_regs: RTL and testbench
==================================

Name: i2c_master_regs

Overview:
- Host-side control/status register file of an I2C master.
- Sits between a simple synchronous system data bus (address, data in/out, write strobe) and the I2C byte/bit controller core.
- Holds prescale, control, transmit, command and status registers; drives the core's command/config signals and raises an interrupt request.
- Core completion, arbitration-loss, receive data, received-ACK and busy indications are inputs.

Parameters:
- DWIDTH, 8, system data bus width; all registers are 8 bits.
- AWIDTH, 3, system address width.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Addr  in  AWIDTH  register address.
- DataIn  in  DWIDTH  write data.
- DataOut  out  DWIDTH  read data.
- Wr  in  1  write enable; 1 = write DataIn to Addr this edge.
- Int  out  1  interrupt request.
- Start  out  1  CR.STA.
- Stop  out  1  CR.STO.
- Read  out  1  CR.RD.
- Write  out  1  CR.WR.
- Tx_ack  out  1  CR.ACK (0 = send ACK, 1 = NACK).
- Rx_ack  in  1  ACK bit received from slave.
- Rx_data  in  8  byte received from slave.
- Tx_data  out  8  TXR contents.
- Prescale  out  8  PRER contents.
- I2C_busy  in  1  bus busy.
- I2C_done  in  1  one-cycle pulse, byte transfer complete.
- I2C_en  out  1  CTR.EN.
- I2C_al  in  1  one-cycle pulse, arbitration lost.

Behaviour:
Clock and reset:
- One clock, Clk.
- Reset is Rst_n, asynchronous and active-low.
- Reset values: PRER = 0xFF; CTR, TXR, CR, SR state, DataOut and Int = 0.

Address map:
- 0 PRER (R/W).
- 1 CTR (R/W, all 8 bits stored): bit7 EN, bit6 IEN.
- 2 TXR (R/W).
- 3 RXR (RO) = Rx_data.
- 4 CR (R/W): bit7 STA, 6 STO, 5 RD, 4 WR, 3 ACK, 2 AL_ACK, 1 reserved (reads 0), 0 IACK.
- 5 SR (RO): bit7 RxACK = Rx_ack, 6 BUSY = I2C_busy, 5 AL, 4:2 zero, 1 TIP, 0 IF.
- 6–7 read 0; writes to 3, 5, 6, 7 are ignored.

Bus timing:
- Write: on the rising edge with Wr = 1, DataIn is stored into Addr.
- CR writes take effect only when CTR.EN = 1 (or when the same edge's CTR.EN is already 1).
- Read: DataOut is registered; it reflects register[Addr] sampled on each rising edge, giving one-cycle latency.
- Read-after-write to the same address in the next cycle returns the new value.

Command auto-clear:
- If I2C_done or I2C_al is 1, STA, STO, RD and WR clear to 0 on that edge.
- ACK is retained.
- IACK and AL_ACK self-clear one cycle after being written 1, and always read back 0 one cycle later.
- A CR write in the same cycle as done/al takes priority.

Status bits:
- TIP = RD | WR (combinational from CR).
- IF: set on I2C_done or I2C_al; cleared by writing IACK = 1. Set has priority over clear in the same cycle.
- AL: set on I2C_al; cleared by writing AL_ACK = 1. Set has priority.

Outputs:
- Int is registered: Int <= IF & CTR.IEN.
- Start, Stop, Read, Write and Tx_ack mirror the CR bits.
- I2C_en = CTR[7]; Prescale = PRER; Tx_data = TXR.

Test Plan:
- Reg R/W: for addresses 2, 1, 0 write 0xAA, 0x55, 0x00 and read each back -> reads equal the written value; Prescale and Tx_data track PRER and TXR.
- Transfer autoclear: set CTR = 0x80, CR = 0x90 (STA+WR) -> Start = 1, Write = 1, SR.TIP = 1. Pulse I2C_done one cycle with Rx_ack = 1 -> CR reads 0x00, TIP = 0, IF = 1, SR[7] = 1.
- Arbitration lost: CR = 0x20 (RD), pulse I2C_al -> RD cleared, SR.AL = 1, IF = 1. Write CR = 0x04 -> AL = 0, and CR reads 0x00 next cycle.
- Interrupt: CTR = 0xC0, pulse I2C_done -> Int = 1 within 3 cycles. Write CR = 0x01 -> IF = 0, Int = 0. Repeat with an I2C_al source. With IEN = 0, Int stays 0.
- Outputs: CR = 0x48 -> Stop = 1, Tx_ack = 1, others 0. CTR = 0x00 -> I2C_en = 0, and a subsequent CR write is ignored.
- RXR/busy: Rx_data = 0xA5, I2C_busy = 1 -> read addr 3 gives 0xA5, and SR[6] = 1.

Source files
------------

// File: rtl/i2c_master_regs.sv
// -----------------------------------------------------------------------------
// i2c_master_regs
//
// Host-side control/status register file for an I2C master. It sits between a
// simple synchronous system bus and the I2C byte/bit controller core. It holds
// the prescale, control, transmit and command registers, returns status, drives
// the core's command and configuration signals, and raises an interrupt request.
//
// Register map (8-bit registers):
//   0 PRER  R/W  clock prescale
//   1 CTR   R/W  bit7 EN (core enable), bit6 IEN (interrupt enable)
//   2 TXR   R/W  byte to transmit
//   3 RXR   RO   byte received (Rx_data)
//   4 CR    R/W  bit7 STA, 6 STO, 5 RD, 4 WR, 3 ACK, 2 AL_ACK, 1 rsvd, 0 IACK
//   5 SR    RO   bit7 RxACK, 6 BUSY, 5 AL, 1 TIP, 0 IF
//   6-7          read as 0, writes ignored
//
// Ports:
//   Clk, Rst_n          clock and asynchronous active-low reset
//   Addr, DataIn, Wr    system bus write side
//   DataOut             registered read data (one-cycle latency)
//   Int                 registered interrupt request (IF & IEN)
//   Start/Stop/Read/Write/Tx_ack   command bits to the core (CR mirror)
//   Tx_data, Prescale, I2C_en      configuration to the core
//   Rx_ack, Rx_data, I2C_busy      status from the core
//   I2C_done, I2C_al               one-cycle completion / arbitration-lost pulses
// -----------------------------------------------------------------------------
module i2c_master_regs #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 3
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [AWIDTH-1:0] Addr,
    input  logic [DWIDTH-1:0] DataIn,
    output logic [DWIDTH-1:0] DataOut,
    input  logic              Wr,
    output logic              Int,
    output logic              Start,
    output logic              Stop,
    output logic              Read,
    output logic              Write,
    output logic              Tx_ack,
    input  logic              Rx_ack,
    input  logic [7:0]        Rx_data,
    output logic [7:0]        Tx_data,
    output logic [7:0]        Prescale,
    input  logic              I2C_busy,
    input  logic              I2C_done,
    output logic              I2C_en,
    input  logic              I2C_al
);

    localparam logic [AWIDTH-1:0] ADDR_PRER = AWIDTH'(0);
    localparam logic [AWIDTH-1:0] ADDR_CTR  = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] ADDR_TXR  = AWIDTH'(2);
    localparam logic [AWIDTH-1:0] ADDR_RXR  = AWIDTH'(3);
    localparam logic [AWIDTH-1:0] ADDR_CR   = AWIDTH'(4);
    localparam logic [AWIDTH-1:0] ADDR_SR   = AWIDTH'(5);

    logic [7:0] prer_reg, prer_next;
    logic [7:0] ctr_reg,  ctr_next;
    logic [7:0] txr_reg,  txr_next;
    logic [7:0] cr_reg,   cr_next;
    logic       al_reg,   al_next;
    logic       if_reg,   if_next;
    logic       int_reg,  int_next;
    logic [DWIDTH-1:0] data_out_reg, data_out_next;

    logic [7:0] wdata;
    logic       cr_write;
    logic       tip;
    logic [7:0] sr_value;
    logic [7:0] rd_data;

    assign wdata    = DataIn[7:0];
    // Command writes are only accepted while the core is enabled.
    assign cr_write = Wr && (Addr == ADDR_CR) && ctr_reg[7];
    assign tip      = cr_reg[5] | cr_reg[4];
    assign sr_value = {Rx_ack, I2C_busy, al_reg, 3'b000, tip, if_reg};

    // Read mux. The acknowledge strobes (AL_ACK, IACK) and the reserved bit
    // are never visible on a CR read.
    always_comb begin
        rd_data = 8'h00;
        case (Addr)
            ADDR_PRER: rd_data = prer_reg;
            ADDR_CTR:  rd_data = ctr_reg;
            ADDR_TXR:  rd_data = txr_reg;
            ADDR_RXR:  rd_data = Rx_data;
            ADDR_CR:   rd_data = {cr_reg[7:3], 3'b000};
            ADDR_SR:   rd_data = sr_value;
            default:   rd_data = 8'h00;
        endcase
    end

    always_comb begin
        prer_next     = prer_reg;
        ctr_next      = ctr_reg;
        txr_next      = txr_reg;
        cr_next       = cr_reg;
        al_next       = al_reg;
        if_next       = if_reg;
        int_next      = if_reg & ctr_reg[6];
        data_out_next = DWIDTH'(rd_data);

        if (Wr && (Addr == ADDR_PRER)) prer_next = wdata;
        if (Wr && (Addr == ADDR_CTR))  ctr_next  = wdata;
        if (Wr && (Addr == ADDR_TXR))  txr_next  = wdata;

        // A host write to CR wins over the core's auto-clear on the same edge.
        // Otherwise the transfer command bits drop when the core finishes or
        // loses arbitration; ACK is sticky and the acknowledge strobes last
        // exactly one cycle.
        if (cr_write) begin
            cr_next = {wdata[7:2], 1'b0, wdata[0]};
        end else begin
            if (I2C_done || I2C_al) cr_next[7:4] = 4'b0000;
            cr_next[2] = 1'b0;
            cr_next[1] = 1'b0;
            cr_next[0] = 1'b0;
        end

        // Flag set wins over acknowledge so an event arriving while the host
        // acknowledges the previous one is not lost.
        if (I2C_done || I2C_al) if_next = 1'b1;
        else if (cr_reg[0])     if_next = 1'b0;

        if (I2C_al)         al_next = 1'b1;
        else if (cr_reg[2]) al_next = 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prer_reg     <= 8'hFF;
            ctr_reg      <= 8'h00;
            txr_reg      <= 8'h00;
            cr_reg       <= 8'h00;
            al_reg       <= 1'b0;
            if_reg       <= 1'b0;
            int_reg      <= 1'b0;
            data_out_reg <= '0;
        end else begin
            prer_reg     <= prer_next;
            ctr_reg      <= ctr_next;
            txr_reg      <= txr_next;
            cr_reg       <= cr_next;
            al_reg       <= al_next;
            if_reg       <= if_next;
            int_reg      <= int_next;
            data_out_reg <= data_out_next;
        end
    end

    assign DataOut  = data_out_reg;
    assign Int      = int_reg;
    assign Start    = cr_reg[7];
    assign Stop     = cr_reg[6];
    assign Read     = cr_reg[5];
    assign Write    = cr_reg[4];
    assign Tx_ack   = cr_reg[3];
    assign I2C_en   = ctr_reg[7];
    assign Prescale = prer_reg;
    assign Tx_data  = txr_reg;

endmodule

// File: tb/tb_i2c_master_regs.sv
// -----------------------------------------------------------------------------
// tb_i2c_master_regs
//
// Self-checking bench for i2c_master_regs: a table of register write/read
// vectors followed by hand-written sequences for command auto-clear,
// arbitration loss, interrupt generation, output mirroring and status reads.
// -----------------------------------------------------------------------------
module tb_i2c_master_regs;

    logic       Clk;
    logic       Rst_n;
    logic [2:0] Addr;
    logic [7:0] DataIn;
    logic [7:0] DataOut;
    logic       Wr;
    logic       Int;
    logic       Start, Stop, Read, Write, Tx_ack;
    logic       Rx_ack;
    logic [7:0] Rx_data;
    logic [7:0] Tx_data;
    logic [7:0] Prescale;
    logic       I2C_busy;
    logic       I2C_done;
    logic       I2C_en;
    logic       I2C_al;

    int checks   = 0;
    int failures = 0;

    i2c_master_regs #(.DWIDTH(8), .AWIDTH(3)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Addr     (Addr),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .Wr       (Wr),
        .Int      (Int),
        .Start    (Start),
        .Stop     (Stop),
        .Read     (Read),
        .Write    (Write),
        .Tx_ack   (Tx_ack),
        .Rx_ack   (Rx_ack),
        .Rx_data  (Rx_data),
        .Tx_data  (Tx_data),
        .Prescale (Prescale),
        .I2C_busy (I2C_busy),
        .I2C_done (I2C_done),
        .I2C_en   (I2C_en),
        .I2C_al   (I2C_al)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        logic [7:0] exp_read;
        logic [7:0] exp_prescale;
        logic [7:0] exp_txdata;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, actual, expected);
        end else begin
            $display("ok   %s: 0x%02h", name, actual);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        Addr = a; DataIn = d; Wr = 1'b1;
        step();
        Wr = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        Addr = a; Wr = 1'b0;
        step();
        d = DataOut;
    endtask

    task automatic pulse_done();
        I2C_done = 1'b1;
        step();
        I2C_done = 1'b0;
    endtask

    task automatic pulse_al();
        I2C_al = 1'b1;
        step();
        I2C_al = 1'b0;
    endtask

    // Waits up to n edges for Int to rise, then records the result.
    task automatic expect_int_within(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            if (Int !== 1'b1) step();
        end
        check(name, {7'b0, Int}, 8'h01);
    endtask

    logic [7:0] r;

    initial begin
        vecs[0] = '{3'd2, 8'hAA, 8'hAA, 8'hFF, 8'hAA};
        vecs[1] = '{3'd2, 8'h55, 8'h55, 8'hFF, 8'h55};
        vecs[2] = '{3'd2, 8'h00, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{3'd1, 8'hAA, 8'hAA, 8'hFF, 8'h00};
        vecs[4] = '{3'd1, 8'h55, 8'h55, 8'hFF, 8'h00};
        vecs[5] = '{3'd1, 8'h00, 8'h00, 8'hFF, 8'h00};
        vecs[6] = '{3'd0, 8'hAA, 8'hAA, 8'hAA, 8'h00};
        vecs[7] = '{3'd0, 8'h55, 8'h55, 8'h55, 8'h00};
        vecs[8] = '{3'd0, 8'h00, 8'h00, 8'h00, 8'h00};

        Rst_n = 1'b0; Addr = 3'd0; DataIn = 8'h00; Wr = 1'b0;
        Rx_ack = 1'b0; Rx_data = 8'h00; I2C_busy = 1'b0;
        I2C_done = 1'b0; I2C_al = 1'b0;
        idle(2);

        // ---- reset state ----
        check("reset_dataout", DataOut, 8'h00);
        check("reset_int", {7'b0, Int}, 8'h00);
        check("reset_prescale", Prescale, 8'hFF);
        check("reset_txdata", Tx_data, 8'h00);
        check("reset_cmd_outs", {3'b0, Start, Stop, Read, Write, Tx_ack}, 8'h00);
        check("reset_en", {7'b0, I2C_en}, 8'h00);
        Rst_n = 1'b1;
        rd(3'd0, r); check("reset_prer_read", r, 8'hFF);
        rd(3'd4, r); check("reset_cr_read", r, 8'h00);
        rd(3'd5, r); check("reset_sr_read", r, 8'h00);

        // ---- register read/write table ----
        for (int i = 0; i < 9; i++) begin
            wr(vecs[i].addr, vecs[i].data);
            rd(vecs[i].addr, r);
            check($sformatf("rw[%0d]_read", i), r, vecs[i].exp_read);
            check($sformatf("rw[%0d]_prescale", i), Prescale, vecs[i].exp_prescale);
            check($sformatf("rw[%0d]_txdata", i), Tx_data, vecs[i].exp_txdata);
        end

        // ---- transfer with auto-clear ----
        wr(3'd1, 8'h80);
        wr(3'd4, 8'h90);
        check("xfer_start_write", {6'b0, Start, Write}, 8'h03);
        rd(3'd5, r); check("xfer_sr_tip", r, 8'h02);
        Rx_ack = 1'b1;
        pulse_done();
        rd(3'd4, r); check("xfer_cr_cleared", r, 8'h00);
        rd(3'd5, r); check("xfer_sr_done", r, 8'h81);
        Rx_ack = 1'b0;
        wr(3'd4, 8'h01);
        idle(1);
        rd(3'd5, r); check("xfer_if_cleared", r, 8'h00);

        // ---- arbitration lost ----
        wr(3'd4, 8'h20);
        check("al_read_set", {7'b0, Read}, 8'h01);
        pulse_al();
        check("al_read_cleared", {7'b0, Read}, 8'h00);
        rd(3'd5, r); check("al_sr_set", r, 8'h21);
        wr(3'd4, 8'h04);
        rd(3'd4, r); check("al_ack_cr_reads0", r, 8'h00);
        idle(1);
        rd(3'd5, r); check("al_sr_cleared", r, 8'h01);
        wr(3'd4, 8'h01);
        idle(1);
        rd(3'd5, r); check("al_if_cleared", r, 8'h00);

        // ---- same-edge CR write beats auto-clear ----
        I2C_done = 1'b1;
        wr(3'd4, 8'h10);
        I2C_done = 1'b0;
        check("prio_write_kept", {7'b0, Write}, 8'h01);
        rd(3'd5, r); check("prio_sr", r, 8'h03);
        wr(3'd4, 8'h01);
        idle(1);
        pulse_done();
        rd(3'd5, r); check("prio_sr_after_done", r, 8'h01);
        wr(3'd4, 8'h01);
        idle(1);

        // ---- interrupt from done ----
        wr(3'd1, 8'hC0);
        pulse_done();
        expect_int_within("int_done_set", 3);
        wr(3'd4, 8'h01);
        idle(2);
        check("int_done_cleared", {7'b0, Int}, 8'h00);
        rd(3'd5, r); check("int_done_if0", r, 8'h00);

        // ---- interrupt from arbitration loss ----
        pulse_al();
        expect_int_within("int_al_set", 3);
        wr(3'd4, 8'h05);
        idle(2);
        check("int_al_cleared", {7'b0, Int}, 8'h00);
        rd(3'd5, r); check("int_al_sr0", r, 8'h00);

        // ---- IEN = 0 keeps Int low ----
        wr(3'd1, 8'h80);
        pulse_done();
        idle(3);
        check("int_masked", {7'b0, Int}, 8'h00);
        wr(3'd4, 8'h01);
        idle(1);

        // ---- command output mirroring and EN gating ----
        wr(3'd4, 8'h48);
        check("outs_stop_ack", {3'b0, Start, Stop, Read, Write, Tx_ack}, 8'h09);
        wr(3'd1, 8'h00);
        check("outs_en_off", {7'b0, I2C_en}, 8'h00);
        wr(3'd4, 8'h90);
        check("outs_cr_ignored", {3'b0, Start, Stop, Read, Write, Tx_ack}, 8'h09);
        rd(3'd4, r); check("outs_cr_read", r, 8'h48);

        // ---- RXR and busy ----
        Rx_data = 8'hA5; I2C_busy = 1'b1;
        rd(3'd3, r); check("rxr_read", r, 8'hA5);
        rd(3'd5, r); check("sr_busy", r, 8'h40);
        wr(3'd6, 8'h77);
        rd(3'd6, r); check("addr6_reads0", r, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
